// File: rtl/audio_i2s_frame_source_if.sv
// Bundle between the synth engine, the frame source and the I2S serializer.
// The frame source (clock master) uses modport master; its neighbours use slave.
interface audio_i2s_frame_source_if #(
    parameter int SAMPLE_W = 24
);
    logic [SAMPLE_W-1:0] i_lsound_in;
    logic [SAMPLE_W-1:0] i_rsound_in;
    logic                i_valid;
    logic                o_ready;
    logic                oAUD_BCLK;
    logic                oAUD_DACLRCK;
    logic [SAMPLE_W-1:0] o_lsound_out;
    logic [SAMPLE_W-1:0] o_rsound_out;
    logic                o_frame_strobe;
    logic                o_underrun;
    logic                i_underrun_clr;

    modport master (
        input  i_lsound_in, i_rsound_in, i_valid, i_underrun_clr,
        output o_ready, oAUD_BCLK, oAUD_DACLRCK,
        output o_lsound_out, o_rsound_out, o_frame_strobe, o_underrun
    );

    modport slave (
        output i_lsound_in, i_rsound_in, i_valid, i_underrun_clr,
        input  o_ready, oAUD_BCLK, oAUD_DACLRCK,
        input  o_lsound_out, o_rsound_out, o_frame_strobe, o_underrun
    );
endinterface

// File: rtl/audio_i2s_frame_source.sv
// I2S BCLK/LRCK generator with a stereo sample FIFO that presents one pair per 64-BCLK frame.
// Optional macro AUDIO_UNDERRUN_MUTE_EN: load silence on underrun instead of repeating the last pair.
module audio_i2s_frame_source #(
    parameter int BCLK_DIV   = 8,
    parameter int SAMPLE_W   = 24,
    parameter int FIFO_DEPTH = 4
) (
    input logic                      iCLK,
    input logic                      reset_reg,
    audio_i2s_frame_source_if.master aud
);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [DIV_W-1:0]    div_cnt;
    logic                bclk;
    logic                lrck;
    logic [5:0]          bit_cnt;
    logic [5:0]          bit_cnt_nxt;
    logic                div_done;
    logic                bclk_fall;
    logic                frame_start;

    logic [SAMPLE_W-1:0] fifo_l [FIFO_DEPTH];
    logic [SAMPLE_W-1:0] fifo_r [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W:0]      count;
    logic                fifo_empty;
    logic                ready;
    logic                push;
    logic                pop;

    logic [SAMPLE_W-1:0] lsound;
    logic [SAMPLE_W-1:0] rsound;
    logic                strobe;
    logic                underrun;

    // A frame starts on the BCLK falling toggle that wraps bit_cnt 63->0.
    assign div_done    = (div_cnt == DIV_LAST);
    assign bclk_fall   = div_done && bclk;
    assign bit_cnt_nxt = bit_cnt + 6'd1;
    assign frame_start = bclk_fall && (bit_cnt == 6'd63);

    assign fifo_empty = (count == '0);
    assign ready      = (count < DEPTH_CNT);
    assign push       = aud.i_valid && ready;
    assign pop        = frame_start && !fifo_empty;

    always_ff @(posedge iCLK) begin
        if (reset_reg) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
            bit_cnt <= '0;
            lrck    <= 1'b0;
        end else if (div_done) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
            if (bclk) begin
                bit_cnt <= bit_cnt_nxt;
                lrck    <= bit_cnt_nxt[5];
            end
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Storage is not reset; clearing the pointers is enough to discard it.
    always_ff @(posedge iCLK) begin
        if (push) begin
            fifo_l[wr_ptr] <= aud.i_lsound_in;
            fifo_r[wr_ptr] <= aud.i_rsound_in;
        end
    end

    always_ff @(posedge iCLK) begin
        if (reset_reg) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sample registers only change at frame start, so they hold across the frame.
    always_ff @(posedge iCLK) begin
        if (reset_reg) begin
            lsound   <= '0;
            rsound   <= '0;
            strobe   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            strobe <= frame_start;
            if (pop) begin
                lsound <= fifo_l[rd_ptr];
                rsound <= fifo_r[rd_ptr];
            end
`ifdef AUDIO_UNDERRUN_MUTE_EN
            else if (frame_start) begin
                lsound <= '0;
                rsound <= '0;
            end
`endif
            if (frame_start && fifo_empty) begin
                underrun <= 1'b1;
            end else if (aud.i_underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

    assign aud.o_ready        = ready;
    assign aud.oAUD_BCLK      = bclk;
    assign aud.oAUD_DACLRCK   = lrck;
    assign aud.o_lsound_out   = lsound;
    assign aud.o_rsound_out   = rsound;
    assign aud.o_frame_strobe = strobe;
    assign aud.o_underrun     = underrun;
endmodule

// File: tb/tb_audio_i2s_frame_source.sv
// Scoreboard bench for audio_i2s_frame_source (BCLK_DIV=2); follows AUDIO_UNDERRUN_MUTE_EN if defined.
module tb_audio_i2s_frame_source;
    localparam int BCLK_DIV     = 2;
    localparam int SAMPLE_W     = 24;
    localparam int FIFO_DEPTH   = 4;
    localparam int FRAME_CYCLES = 2 * BCLK_DIV * 64;
    localparam int WAIT_LIMIT   = FRAME_CYCLES + 64;

    logic iCLK = 1'b0;
    logic reset_reg;
    int   checks = 0;
    int   errors = 0;

    logic [2*SAMPLE_W-1:0] exp_q[$];
    int                    model_count;
    logic [SAMPLE_W-1:0]   last_l;
    logic [SAMPLE_W-1:0]   last_r;

    audio_i2s_frame_source_if #(.SAMPLE_W(SAMPLE_W)) aud ();

    audio_i2s_frame_source #(
        .BCLK_DIV  (BCLK_DIV),
        .SAMPLE_W  (SAMPLE_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .iCLK     (iCLK),
        .reset_reg(reset_reg),
        .aud      (aud)
    );

    always #5 iCLK = ~iCLK;

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic wait_strobe(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (aud.o_frame_strobe !== 1'b1 && cycles < WAIT_LIMIT);
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_count = 0;
        last_l = '0;
        last_r = '0;
    endtask

    // Expected presentation at a frame start, taken before any same-edge push.
    task automatic model_frame(output logic [SAMPLE_W-1:0] el, output logic [SAMPLE_W-1:0] er, output logic eu);
        if (exp_q.size() != 0) begin
            {last_l, last_r} = exp_q.pop_front();
            model_count--;
            eu = 1'b0;
        end else begin
            eu = 1'b1;
`ifdef AUDIO_UNDERRUN_MUTE_EN
            last_l = '0;
            last_r = '0;
`endif
        end
        el = last_l;
        er = last_r;
    endtask

    task automatic push_pair(input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r);
        aud.i_lsound_in = l;
        aud.i_rsound_in = r;
        aud.i_valid     = 1'b1;
        if (model_count < FIFO_DEPTH) begin
            exp_q.push_back({l, r});
            model_count++;
        end
        tick();
        aud.i_valid = 1'b0;
    endtask

    task automatic test_reset();
        aud.i_valid = 1'b0;
        aud.i_underrun_clr = 1'b0;
        aud.i_lsound_in = '0;
        aud.i_rsound_in = '0;
        reset_reg = 1'b1;
        repeat (3) tick();
        model_reset();
        checks++; if (aud.oAUD_BCLK !== 1'b0) begin errors++; $display("[TB] FAIL reset_bclk actual %0b required 0", aud.oAUD_BCLK); end
        checks++; if (aud.oAUD_DACLRCK !== 1'b0) begin errors++; $display("[TB] FAIL reset_lrck actual %0b required 0", aud.oAUD_DACLRCK); end
        checks++; if (aud.o_lsound_out !== '0) begin errors++; $display("[TB] FAIL reset_l actual %h required 0", aud.o_lsound_out); end
        checks++; if (aud.o_rsound_out !== '0) begin errors++; $display("[TB] FAIL reset_r actual %h required 0", aud.o_rsound_out); end
        checks++; if (aud.o_frame_strobe !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobe actual %0b required 0", aud.o_frame_strobe); end
        checks++; if (aud.o_underrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_underrun actual %0b required 0", aud.o_underrun); end
        checks++; if (aud.o_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready actual %0b required 1", aud.o_ready); end
        reset_reg = 1'b0;
    endtask

    // Edge k after reset release: BCLK = k/DIV mod 2, LRCK = bit_cnt[5], frame start at k = 256.
    task automatic test_clocks();
        int bclk_err;
        int lrck_err;
        int strobe_err;
        logic exp_b;
        logic exp_lr;
        logic exp_s;
        logic [SAMPLE_W-1:0] el;
        logic [SAMPLE_W-1:0] er;
        logic eu;
        bclk_err = 0;
        lrck_err = 0;
        strobe_err = 0;
        for (int k = 1; k <= FRAME_CYCLES; k++) begin
            tick();
            exp_b  = ((k / BCLK_DIV) % 2) == 1;
            exp_lr = ((k / (2 * BCLK_DIV)) % 64) >= 32;
            exp_s  = (k == FRAME_CYCLES);
            if (aud.oAUD_BCLK !== exp_b) bclk_err++;
            if (aud.oAUD_DACLRCK !== exp_lr) lrck_err++;
            if (aud.o_frame_strobe !== exp_s) strobe_err++;
        end
        checks++; if (bclk_err != 0) begin errors++; $display("[TB] FAIL clocks_bclk_pattern actual %0d bad cycles required 0", bclk_err); end
        checks++; if (lrck_err != 0) begin errors++; $display("[TB] FAIL clocks_lrck_pattern actual %0d bad cycles required 0", lrck_err); end
        checks++; if (strobe_err != 0) begin errors++; $display("[TB] FAIL clocks_strobe_pattern actual %0d bad cycles required 0", strobe_err); end
        model_frame(el, er, eu);
        checks++; if (aud.o_underrun !== eu) begin errors++; $display("[TB] FAIL first_frame_underrun actual %0b required %0b", aud.o_underrun, eu); end
        checks++; if (aud.o_lsound_out !== el) begin errors++; $display("[TB] FAIL first_frame_l actual %h required %h", aud.o_lsound_out, el); end
        checks++; if (aud.o_rsound_out !== er) begin errors++; $display("[TB] FAIL first_frame_r actual %h required %h", aud.o_rsound_out, er); end
    endtask

    task automatic test_underrun_clear();
        aud.i_underrun_clr = 1'b1;
        tick();
        aud.i_underrun_clr = 1'b0;
        checks++; if (aud.o_underrun !== 1'b0) begin errors++; $display("[TB] FAIL underrun_clear actual %0b required 0", aud.o_underrun); end
    endtask

    task automatic test_in_order();
        int c;
        logic [SAMPLE_W-1:0] el;
        logic [SAMPLE_W-1:0] er;
        logic eu;
        push_pair(24'h111111, 24'h222222);
        push_pair(24'h333333, 24'h444444);
        checks++; if (aud.o_ready !== (model_count < FIFO_DEPTH)) begin errors++; $display("[TB] FAIL inorder_ready actual %0b required %0b", aud.o_ready, model_count < FIFO_DEPTH); end
        wait_strobe(c);
        model_frame(el, er, eu);
        checks++; if (aud.o_frame_strobe !== 1'b1) begin errors++; $display("[TB] FAIL inorder_strobe0 actual %0b required 1 after %0d cycles", aud.o_frame_strobe, c); end
        checks++; if (aud.o_lsound_out !== el) begin errors++; $display("[TB] FAIL inorder_l0 actual %h required %h", aud.o_lsound_out, el); end
        checks++; if (aud.o_rsound_out !== er) begin errors++; $display("[TB] FAIL inorder_r0 actual %h required %h", aud.o_rsound_out, er); end
        checks++; if (aud.o_underrun !== eu) begin errors++; $display("[TB] FAIL inorder_underrun0 actual %0b required %0b", aud.o_underrun, eu); end
        tick();
        checks++; if (aud.o_frame_strobe !== 1'b0) begin errors++; $display("[TB] FAIL inorder_strobe_width actual %0b required 0", aud.o_frame_strobe); end
        checks++; if (aud.o_lsound_out !== el) begin errors++; $display("[TB] FAIL inorder_l0_hold actual %h required %h", aud.o_lsound_out, el); end
        wait_strobe(c);
        checks++; if (c != FRAME_CYCLES - 1) begin errors++; $display("[TB] FAIL inorder_frame_period actual %0d required %0d", c, FRAME_CYCLES - 1); end
        model_frame(el, er, eu);
        checks++; if (aud.o_lsound_out !== el) begin errors++; $display("[TB] FAIL inorder_l1 actual %h required %h", aud.o_lsound_out, el); end
        checks++; if (aud.o_rsound_out !== er) begin errors++; $display("[TB] FAIL inorder_r1 actual %h required %h", aud.o_rsound_out, er); end
        checks++; if (aud.o_underrun !== eu) begin errors++; $display("[TB] FAIL inorder_underrun1 actual %0b required %0b", aud.o_underrun, eu); end
    endtask

    // Entered on a strobe cycle: the next frame start edge is FRAME_CYCLES edges away.
    task automatic test_clear_vs_set();
        logic [SAMPLE_W-1:0] el;
        logic [SAMPLE_W-1:0] er;
        logic eu;
        repeat (FRAME_CYCLES - 1) tick();
        aud.i_underrun_clr = 1'b1;
        model_frame(el, er, eu);
        tick();
        checks++; if (aud.o_frame_strobe !== 1'b1) begin errors++; $display("[TB] FAIL setwins_strobe actual %0b required 1", aud.o_frame_strobe); end
        checks++; if (aud.o_underrun !== eu) begin errors++; $display("[TB] FAIL setwins_underrun actual %0b required %0b", aud.o_underrun, eu); end
        checks++; if (aud.o_lsound_out !== el) begin errors++; $display("[TB] FAIL underrun_l actual %h required %h", aud.o_lsound_out, el); end
        checks++; if (aud.o_rsound_out !== er) begin errors++; $display("[TB] FAIL underrun_r actual %h required %h", aud.o_rsound_out, er); end
        tick();
        aud.i_underrun_clr = 1'b0;
        checks++; if (aud.o_underrun !== 1'b0) begin errors++; $display("[TB] FAIL setwins_clear_next actual %0b required 0", aud.o_underrun); end
    endtask

    task automatic test_full();
        int c;
        logic [SAMPLE_W-1:0] el;
        logic [SAMPLE_W-1:0] er;
        logic eu;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            push_pair(SAMPLE_W'(24'hA00000 + i), SAMPLE_W'(24'hB00000 + i));
        end
        checks++; if (aud.o_ready !== (model_count < FIFO_DEPTH)) begin errors++; $display("[TB] FAIL full_ready actual %0b required %0b", aud.o_ready, model_count < FIFO_DEPTH); end
        push_pair(24'hDEAD00, 24'hBEEF00);
        checks++; if (aud.o_ready !== (model_count < FIFO_DEPTH)) begin errors++; $display("[TB] FAIL full_drop_ready actual %0b required %0b", aud.o_ready, model_count < FIFO_DEPTH); end
        wait_strobe(c);
        model_frame(el, er, eu);
        checks++; if (aud.o_frame_strobe !== 1'b1) begin errors++; $display("[TB] FAIL full_strobe actual %0b required 1 after %0d cycles", aud.o_frame_strobe, c); end
        checks++; if (aud.o_lsound_out !== el) begin errors++; $display("[TB] FAIL full_pop_l actual %h required %h", aud.o_lsound_out, el); end
        checks++; if (aud.o_rsound_out !== er) begin errors++; $display("[TB] FAIL full_pop_r actual %h required %h", aud.o_rsound_out, er); end
        checks++; if (aud.o_ready !== (model_count < FIFO_DEPTH)) begin errors++; $display("[TB] FAIL full_ready_after_pop actual %0b required %0b", aud.o_ready, model_count < FIFO_DEPTH); end
    endtask

    // Push on the frame start edge while the FIFO holds data, then drain in order.
    task automatic test_back_to_back();
        int c;
        bit accept;
        logic [SAMPLE_W-1:0] el;
        logic [SAMPLE_W-1:0] er;
        logic eu;
        repeat (FRAME_CYCLES - 1) tick();
        accept = (model_count < FIFO_DEPTH);
        model_frame(el, er, eu);
        if (accept) begin
            exp_q.push_back({24'hC0FFEE, 24'h0DDBA1});
            model_count++;
        end
        aud.i_lsound_in = 24'hC0FFEE;
        aud.i_rsound_in = 24'h0DDBA1;
        aud.i_valid = 1'b1;
        tick();
        aud.i_valid = 1'b0;
        checks++; if (aud.o_frame_strobe !== 1'b1) begin errors++; $display("[TB] FAIL b2b_strobe actual %0b required 1", aud.o_frame_strobe); end
        checks++; if (aud.o_lsound_out !== el) begin errors++; $display("[TB] FAIL b2b_l actual %h required %h", aud.o_lsound_out, el); end
        checks++; if (aud.o_ready !== (model_count < FIFO_DEPTH)) begin errors++; $display("[TB] FAIL b2b_ready actual %0b required %0b", aud.o_ready, model_count < FIFO_DEPTH); end
        for (int f = 0; f < 3; f++) begin
            wait_strobe(c);
            model_frame(el, er, eu);
            checks++; if (aud.o_lsound_out !== el) begin errors++; $display("[TB] FAIL b2b_drain_l%0d actual %h required %h", f, aud.o_lsound_out, el); end
            checks++; if (aud.o_rsound_out !== er) begin errors++; $display("[TB] FAIL b2b_drain_r%0d actual %h required %h", f, aud.o_rsound_out, er); end
            checks++; if (aud.o_underrun !== eu) begin errors++; $display("[TB] FAIL b2b_drain_underrun%0d actual %0b required %0b", f, aud.o_underrun, eu); end
        end
    endtask

    // A pair pushed into an empty FIFO on the frame start edge waits for the next frame.
    task automatic test_push_into_empty();
        int c;
        bit accept;
        logic [SAMPLE_W-1:0] el;
        logic [SAMPLE_W-1:0] er;
        logic eu;
        repeat (FRAME_CYCLES - 1) tick();
        accept = (model_count < FIFO_DEPTH);
        model_frame(el, er, eu);
        if (accept) begin
            exp_q.push_back({24'h5A5A5A, 24'hA5A5A5});
            model_count++;
        end
        aud.i_lsound_in = 24'h5A5A5A;
        aud.i_rsound_in = 24'hA5A5A5;
        aud.i_valid = 1'b1;
        tick();
        aud.i_valid = 1'b0;
        checks++; if (aud.o_underrun !== eu) begin errors++; $display("[TB] FAIL empty_push_underrun actual %0b required %0b", aud.o_underrun, eu); end
        checks++; if (aud.o_lsound_out !== el) begin errors++; $display("[TB] FAIL empty_push_l actual %h required %h", aud.o_lsound_out, el); end
        checks++; if (aud.o_rsound_out !== er) begin errors++; $display("[TB] FAIL empty_push_r actual %h required %h", aud.o_rsound_out, er); end
        wait_strobe(c);
        checks++; if (c != FRAME_CYCLES) begin errors++; $display("[TB] FAIL empty_push_period actual %0d required %0d", c, FRAME_CYCLES); end
        model_frame(el, er, eu);
        checks++; if (aud.o_lsound_out !== el) begin errors++; $display("[TB] FAIL empty_push_next_l actual %h required %h", aud.o_lsound_out, el); end
        checks++; if (aud.o_rsound_out !== er) begin errors++; $display("[TB] FAIL empty_push_next_r actual %h required %h", aud.o_rsound_out, er); end
    endtask

    // Entered on a strobe cycle; reset lands at bit_cnt = 40 with one pair queued.
    task automatic test_reset_mid_frame();
        int c;
        logic [SAMPLE_W-1:0] el;
        logic [SAMPLE_W-1:0] er;
        logic eu;
        push_pair(24'h777777, 24'h888888);
        repeat (40 * 2 * BCLK_DIV - 1) tick();
        checks++; if (aud.oAUD_DACLRCK !== 1'b1) begin errors++; $display("[TB] FAIL midreset_pre_lrck actual %0b required 1", aud.oAUD_DACLRCK); end
        reset_reg = 1'b1;
        tick();
        model_reset();
        checks++; if (aud.oAUD_BCLK !== 1'b0) begin errors++; $display("[TB] FAIL midreset_bclk actual %0b required 0", aud.oAUD_BCLK); end
        checks++; if (aud.oAUD_DACLRCK !== 1'b0) begin errors++; $display("[TB] FAIL midreset_lrck actual %0b required 0", aud.oAUD_DACLRCK); end
        checks++; if (aud.o_lsound_out !== '0) begin errors++; $display("[TB] FAIL midreset_l actual %h required 0", aud.o_lsound_out); end
        checks++; if (aud.o_rsound_out !== '0) begin errors++; $display("[TB] FAIL midreset_r actual %h required 0", aud.o_rsound_out); end
        checks++; if (aud.o_underrun !== 1'b0) begin errors++; $display("[TB] FAIL midreset_underrun actual %0b required 0", aud.o_underrun); end
        checks++; if (aud.o_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready actual %0b required 1", aud.o_ready); end
        reset_reg = 1'b0;
        wait_strobe(c);
        checks++; if (c != FRAME_CYCLES) begin errors++; $display("[TB] FAIL midreset_frame_delay actual %0d required %0d", c, FRAME_CYCLES); end
        model_frame(el, er, eu);
        checks++; if (aud.o_lsound_out !== el) begin errors++; $display("[TB] FAIL midreset_discard_l actual %h required %h", aud.o_lsound_out, el); end
        checks++; if (aud.o_underrun !== eu) begin errors++; $display("[TB] FAIL midreset_discard_underrun actual %0b required %0b", aud.o_underrun, eu); end
    endtask

    initial begin
        test_reset();
        test_clocks();
        test_underrun_clear();
        test_in_order();
        test_clear_vs_set();
        test_full();
        test_back_to_back();
        test_push_into_empty();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
